// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor: C = A - B over WIDTH cycles, LSB first, reusing one
// full-adder cell with a registered carry (A + ~B + 1). Signed overflow is reported with C.
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_sign;
  logic             b_sign;

  logic             sum;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the shared full-adder cell
  always_comb begin
    state_next = state;
    sum        = sa[0] ^ sb[0] ^ carry;
    carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last_bit   = (cnt == LAST);
    res_next   = {sum, res};
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      C        <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction as A + ~B with the +1 injected through the carry
            sa     <= A;
            sb     <= ~B;
            carry  <= 1'b1;
            a_sign <= A[WIDTH-1];
            b_sign <= B[WIDTH-1];
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          carry <= carry_next;
          res   <= res_next[WIDTH-1:1];
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            C        <= res_next;
            overflow <= (a_sign & ~b_sign & ~sum) | (~a_sign & b_sign & sum);
            done     <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: outputs sampled on the falling edge,
// expected values hand-computed for 6-bit two's-complement subtraction.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] A;
  logic [5:0] B;
  logic       busy;
  logic       done;
  logic [5:0] C;
  logic       overflow;

  int total = 0;
  int passed = 0;
  int failed = 0;

  serial_subtractor #(.WIDTH(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .C        (C),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and check busy/done timing, result and overflow
  task automatic run_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] exp_c, input logic exp_ov);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, int'(busy), 1);
      check({tag, "_done_early"}, int'(done), 0);
    end
    @(negedge clk);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_C"}, int'(C), int'(exp_c));
    check({tag, "_ovf"}, int'(overflow), int'(exp_ov));
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 6'b000000;
    B = 6'b000000;
    #12;
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_C", int'(C), 0);
      check("idle_ovf", int'(overflow), 0);
    end

    // Basic 5 - 3, then hold
    run_op("basic", 6'b000101, 6'b000011, 6'b000010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_C", int'(C), 2);
      check("hold_ovf", int'(overflow), 0);
      check("hold_done", int'(done), 0);
    end

    run_op("neg", 6'b111101, 6'b000101, 6'b111000, 1'b0);
    run_op("negovf", 6'b100000, 6'b000001, 6'b011111, 1'b1);
    run_op("posovf", 6'b011111, 6'b111111, 6'b100000, 1'b1);
    run_op("zero", 6'b000000, 6'b000000, 6'b000000, 1'b0);

    // Start held high: done every 7 cycles; A perturbed mid-operation only
    @(negedge clk);
    A = 6'b000101;
    B = 6'b000011;
    start = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 2) A = 6'b001001;
      if (e == 4) A = 6'b000101;
      if (e == 20) start = 1'b0;
      check("b2b_done", int'(done), (e == 6 || e == 13 || e == 20) ? 1 : 0);
      check("b2b_busy", int'(busy), (e == 6 || e == 13 || e == 20) ? 0 : 1);
      if (e == 6 || e == 13 || e == 20) check("b2b_C", int'(C), 2);
    end

    // Reset mid-operation after a result of 2 is held
    @(negedge clk);
    A = 6'b011111;
    B = 6'b111111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_C", int'(C), 0);
    check("abort_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      check("abort_idle", int'(busy), 0);
    end
    run_op("after_rst", 6'b000101, 6'b000011, 6'b000010, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
